// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and
// the fill value for the divide-by-zero quotient.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // Replicated across the quotient width on divide-by-zero.
  localparam logic DbzQuotFill = 1'b1;

endpackage

// File: rtl/div_trial_sub.sv
// Ripple add/sub slice with the subtract control tied high: diff_o = a_i - b_i,
// borrow_o set when b_i > a_i.
module div_trial_sub #(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] diff_o,
  output logic             borrow_o
);

  localparam logic Sub = 1'b1;

  logic [Width-1:0] b_x;
  logic [Width:0]   carry;

  assign b_x      = b_i ^ {Width{Sub}};
  assign carry[0] = Sub;

  for (genvar i = 0; i < Width; i++) begin : g_ripple
    assign diff_o[i]  = a_i[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_x[i]) | (carry[i] & (a_i[i] ^ b_x[i]));
  end

  // No carry out of a two's-complement subtract means a borrow occurred.
  assign borrow_o = Sub & ~carry[Width];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero flag.
module seq_divider import seq_divider_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // R never exceeds the divisor, so its msb only holds the zero guard bit.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  div_trial_sub #(
    .Width(WIDTH + 1)
  ) u_trial_sub (
    .a_i     (r_shift),
    .b_i     ({1'b0, d_q}),
    .diff_o  (trial_diff),
    .borrow_o(trial_borrow)
  );

  assign r_next    = trial_borrow ? r_shift : trial_diff;
  assign q_next    = {q_q[WIDTH-2:0], ~trial_borrow};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
            state_d = StCalc;
          end else begin
            quot_d  = {WIDTH{DbzQuotFill}};
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          quot_d  = q_next;
          rem_d   = r_next[WIDTH-1:0];
          dbz_d   = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == StCalc);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): latency, results, divide-by-zero,
// ignored start, back-to-back operation and reset abort.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 with start dropped.
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done from cycle lat0, counting busy cycles and output changes.
  task automatic wait_done(input int lat0, output int lat, output int nbusy, output int nchg);
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    q0    = quotient;
    r0    = remainder;
    lat   = lat0;
    nbusy = 0;
    nchg  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      if (quotient !== q0 || remainder !== r0) nchg++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic run_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
    int lat, nbusy, nchg;
    pulse_start(a, b);
    wait_done(1, lat, nbusy, nchg);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_hold"}, 32'(nchg), 32'd0);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, nbusy, nchg, nd;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", 32'(quotient), 32'd0);
    check("reset_r", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("nominal_100_7", 8'd100, 8'd7, 8'd14, 8'd2);
    run_case("max_255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    run_case("small_5_9", 8'd5, 8'd9, 8'd0, 8'd5);
    run_case("eq_255_255", 8'd255, 8'd255, 8'd1, 8'd0);
    run_case("zero_0_3", 8'd0, 8'd3, 8'd0, 8'd0);

    // Divide by zero: done in cycle 1, never busy.
    pulse_start(8'h5A, 8'h00);
    wait_done(1, lat, nbusy, nchg);
    check("dbz_latency", 32'(lat), 32'd1);
    check("dbz_busy_cycles", 32'(nbusy), 32'd0);
    check("dbz_q", 32'(quotient), 32'hFF);
    check("dbz_r", 32'(remainder), 32'h5A);
    check("dbz_flag", 32'(div_by_zero), 32'd1);
    @(negedge clk);
    check("dbz_done_pulse", 32'(done), 32'd0);

    // Start raised mid-calculation must not disturb the operation in flight.
    pulse_start(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, nbusy, nchg);
    check("ign_latency", 32'(lat), 32'd9);
    check("ign_q", 32'(quotient), 32'd66);
    check("ign_r", 32'(remainder), 32'd2);
    check("ign_dbz_cleared", 32'(div_by_zero), 32'd0);
    count_dones(12, nd);
    check("ign_single_done", 32'(nd), 32'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    pulse_start(8'd50, 8'd5);
    wait_done(1, lat, nbusy, nchg);
    check("b2b1_latency", 32'(lat), 32'd9);
    check("b2b1_q", 32'(quotient), 32'd10);
    check("b2b1_r", 32'(remainder), 32'd0);
    pulse_start(8'd77, 8'd10);
    check("b2b2_busy_after_done", 32'(busy), 32'd1);
    wait_done(1, lat, nbusy, nchg);
    check("b2b2_latency", 32'(lat), 32'd9);
    check("b2b2_hold", 32'(nchg), 32'd0);
    check("b2b2_q", 32'(quotient), 32'd7);
    check("b2b2_r", 32'(remainder), 32'd7);

    // Reset mid-calculation aborts with no done.
    pulse_start(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_q", 32'(quotient), 32'd0);
    check("rst_mid_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(12, nd);
    check("rst_mid_no_done", 32'(nd), 32'd0);
    run_case("after_rst_100_7", 8'd100, 8'd7, 8'd14, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
